// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and the calculator FSM.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } scan_state_e;

    // Width of a key index for an n_rows x n_cols matrix (at least one bit).
    function automatic int key_width(input int n_rows, input int n_cols);
        return (n_rows * n_cols > 1) ? $clog2(n_rows * n_cols) : 1;
    endfunction

    typedef enum logic [3:0] {
        SYM_0, SYM_1, SYM_2, SYM_3, SYM_4, SYM_5, SYM_6, SYM_7, SYM_8, SYM_9,
        SYM_ADD, SYM_SUB, SYM_MUL, SYM_EQ, SYM_CLR, SYM_BKSP
    } calc_sym_e;

    // 4x4 key index (row*4+col) to calculator symbol, row 0 at the top.
    localparam calc_sym_e KEY_SYMBOL [16] = '{
        SYM_1,   SYM_2, SYM_3,    SYM_ADD,
        SYM_4,   SYM_5, SYM_6,    SYM_SUB,
        SYM_7,   SYM_8, SYM_9,    SYM_MUL,
        SYM_CLR, SYM_0, SYM_BKSP, SYM_EQ
    };

endpackage

// File: rtl/keypad_event_fifo.sv
// Small key-event FIFO with level, sticky overflow and registered head.
module keypad_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [LW-1:0]    level,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             full;
    logic             accept;
    logic             drop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
    assign pop    = valid && pop_ready;
    assign full   = (level == LW'(DEPTH));
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign valid  = (level != '0);
    assign head   = mem[rd_ptr];

    // Storage, pointers, level and sticky overflow; a drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                level <= level + 1'b1;
            end else if (!accept && pop) begin
                level <= level - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: column drive, row sync/debounce, key encoding,
// optional auto-repeat, events buffered in keypad_event_fifo.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_SCAN     | drive column col_q for DWELL clocks, sample rows at end
// ST_DEBOUNCE | rows nonzero seen, wait for pattern to hold DEBOUNCE clocks
// ST_HELD     | key reported, wait for DEBOUNCE clocks of no rows; repeat
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int DWELL      = 16,
    parameter int DEBOUNCE   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT_DLY = 512,
    localparam int KEY_W     = key_width(N_ROWS, N_COLS),
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              REPEAT_EN,
    input  logic [N_ROWS-1:0] rows,
    output logic [N_COLS-1:0] cols,
    output logic [KEY_W-1:0]  key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_down,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW  = $clog2(N_COLS);
    localparam int DW  = $clog2(DWELL);
    localparam int DBW = $clog2(DEBOUNCE) + 1;
    localparam int RPW = $clog2(REPEAT_DLY) + 1;

    localparam logic [CW-1:0]  COL_LAST   = CW'(N_COLS - 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE - 1);
    localparam logic [RPW-1:0] REP_LAST   = RPW'(REPEAT_DLY - 1);

    logic [N_ROWS-1:0] rs_meta;
    logic [N_ROWS-1:0] rs;

    scan_state_e       state, state_nxt;
    logic [CW-1:0]     col_q, col_nxt, col_adv;
    logic [RW-1:0]     row_q, row_nxt, low_row;
    logic [N_ROWS-1:0] pat_q, pat_nxt;
    logic [DW-1:0]     dwell_cnt, dwell_nxt;
    logic [DBW-1:0]    deb_cnt, deb_nxt;
    logic [DBW-1:0]    rel_cnt, rel_nxt;
    logic [RPW-1:0]    rep_cnt, rep_nxt;
    logic              key_down_q;
    logic              push;
    logic [KEY_W-1:0]  push_code;

    // Two-flop synchroniser on the raw row inputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rs_meta <= '0;
            rs      <= '0;
        end else begin
            rs_meta <= rows;
            rs      <= rs_meta;
        end
    end

    // Lowest set row index of the synchronised pattern.
    always_comb begin
        low_row = '0;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (rs[i]) begin
                low_row = RW'(i);
            end
        end
    end

    assign col_adv   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    assign push_code = KEY_W'(int'(row_q) * N_COLS + int'(col_q));

    // Scanner state, counters and registered column drive.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_SCAN;
            col_q      <= '0;
            row_q      <= '0;
            pat_q      <= '0;
            dwell_cnt  <= '0;
            deb_cnt    <= '0;
            rel_cnt    <= '0;
            rep_cnt    <= '0;
            cols       <= N_COLS'(1);
            key_down_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            col_q      <= col_nxt;
            row_q      <= row_nxt;
            pat_q      <= pat_nxt;
            dwell_cnt  <= dwell_nxt;
            deb_cnt    <= deb_nxt;
            rel_cnt    <= rel_nxt;
            rep_cnt    <= rep_nxt;
            cols       <= EN ? (N_COLS'(1) << col_nxt) : '0;
            key_down_q <= EN && (state_nxt == ST_HELD);
        end
    end

    // Next-state, counter updates and event pushes.
    always_comb begin
        state_nxt = state;
        col_nxt   = col_q;
        row_nxt   = row_q;
        pat_nxt   = pat_q;
        dwell_nxt = dwell_cnt;
        deb_nxt   = deb_cnt;
        rel_nxt   = rel_cnt;
        rep_nxt   = rep_cnt;
        push      = 1'b0;
        if (!EN) begin
            state_nxt = ST_SCAN;
            col_nxt   = '0;
            dwell_nxt = '0;
            deb_nxt   = '0;
            rel_nxt   = '0;
            rep_nxt   = '0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_nxt = '0;
                        if (rs != '0) begin
                            row_nxt   = low_row;
                            pat_nxt   = rs;
                            deb_nxt   = '0;
                            state_nxt = ST_DEBOUNCE;
                        end else begin
                            col_nxt = col_adv;
                        end
                    end else begin
                        dwell_nxt = dwell_cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs == pat_q) begin
                        if (deb_cnt == DEB_LAST) begin
                            push      = 1'b1;
                            state_nxt = ST_HELD;
                            rel_nxt   = '0;
                            rep_nxt   = '0;
                        end else begin
                            deb_nxt = deb_cnt + 1'b1;
                        end
                    end else begin
                        state_nxt = ST_SCAN;
                        col_nxt   = col_adv;
                        dwell_nxt = '0;
                    end
                end
                ST_HELD: begin
                    if (rs == '0 && rel_cnt == DEB_LAST) begin
                        // Release wins over a repeat that would land in the same cycle.
                        state_nxt = ST_SCAN;
                        col_nxt   = col_adv;
                        dwell_nxt = '0;
                        rel_nxt   = '0;
                        rep_nxt   = '0;
                    end else begin
                        rel_nxt = (rs == '0) ? rel_cnt + 1'b1 : '0;
                        if (REPEAT_EN) begin
                            if (rep_cnt == REP_LAST) begin
                                push    = 1'b1;
                                rep_nxt = '0;
                            end else begin
                                rep_nxt = rep_cnt + 1'b1;
                            end
                        end else begin
                            rep_nxt = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_SCAN;
                end
            endcase
        end
    end

    assign key_down = key_down_q;

    keypad_event_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (push),
        .push_data (push_code),
        .pop_ready (key_ready),
        .ovf_clr   (ovf_clr),
        .head      (key_code),
        .valid     (key_valid),
        .level     (fifo_level),
        .overflow  (overflow)
    );

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised matrix-keypad scanner for the FPGA calculator: it drives one column at a time, synchronises and debounces the row inputs, and encodes each press as a key index. Key events go into a small FIFO that the main calculator FSM drains with a valid/ready handshake. It is the generalised successor of the fixed 4×4 keyboard controller and adds:

- arbitrary matrix size,
- configurable scan and debounce timing,
- event buffering with overflow reporting,
- optional auto-repeat.

## Interface

Parameters:
- N_ROWS, 4, number of row inputs (≥1)
- N_COLS, 4, number of column drive outputs (≥2)
- DWELL, 16, clocks each column is driven before its rows are sampled (≥4)
- DEBOUNCE, 8, consecutive clocks a row pattern must hold to count as stable (≥1)
- FIFO_DEPTH, 4, key-event buffer entries (power of two, ≥2)
- REPEAT_DLY, 512, clocks between auto-repeat events while a key is held

Ports:
- CLK  in  1  single clock; all logic on its rising edge
- RESET  in  1  asynchronous, active-high reset
- EN  in  1  scan enable
- REPEAT_EN  in  1  auto-repeat mode
- rows  in  N_ROWS  raw row inputs, high = key closed in driven column
- cols  out  N_COLS  one-hot column drive
- key_code  out  KEY_W  key index row*N_COLS+col, KEY_W = clog2(N_ROWS*N_COLS)
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer pop
- key_down  out  1  a debounced key is currently held
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries stored
- overflow  out  1  sticky, an event was dropped
- ovf_clr  in  1  clears overflow

Reset values: cols = one-hot column 0; key_valid = 0; key_code = 0; key_down = 0; fifo_level = 0; overflow = 0; FSM = SCAN; all counters = 0.

## Operation

- rows pass a 2-flop synchroniser (rs) before any use.
- **SCAN**
  - Drive column c for DWELL clocks.
  - On the last dwell clock, sample rs:
    - rs == 0: advance to column (c+1) mod N_COLS; column N_COLS-1 wraps to column 0.
    - rs != 0: latch r = lowest set row index and pattern p = rs, keep column c, go to DEBOUNCE.
- **DEBOUNCE**
  - Count clocks while rs == p.
  - rs changes before the count reaches DEBOUNCE: discard, go to SCAN at column c+1.
  - Count reaches DEBOUNCE: push code r*N_COLS+c, set key_down, go to HELD.
- **HELD**
  - Column c stays driven.
  - Release counter counts clocks with rs == 0 and resets on any nonzero rs.
  - Release count reaches DEBOUNCE: clear key_down, go to SCAN at column c+1.
  - REPEAT_EN = 1: a repeat counter pushes the same code every REPEAT_DLY clocks while in HELD. The first repeat occurs REPEAT_DLY clocks after the initial push. Counter resets on entry to HELD.
- Only one key is reported at a time. Further keys pressed while holding one are ignored until release. Ghosting is not resolved.
- **EN = 0**
  - cols = 0; FSM forced to SCAN at column 0 with counters cleared; key_down = 0.
  - FIFO contents are kept and still poppable.
  - On EN rising, scanning restarts at column 0.
- **FIFO**
  - Pop occurs when key_valid && key_ready.
  - Push into a full FIFO drops the new event and sets overflow.
  - Push and pop in the same cycle when full: pop first, push accepted, level unchanged, no overflow.
  - Push and pop in the same cycle when empty: the new event is not bypassed; key_valid rises the next cycle.
- overflow stays set until ovf_clr or RESET. If ovf_clr and a drop occur in the same cycle, overflow ends set.
- RESET mid-operation (any state, mid-debounce or held) returns everything to reset values immediately and flushes the FIFO.

## Timing

- key_code and key_valid are registered. key_code is the FIFO head and is stable while key_valid && !key_ready.
- Press latency, rows edge to key_valid high (FIFO empty, column already driven, before its sample point): 2 (sync) + remaining dwell + DEBOUNCE + 1 clocks.
- Worst-case press latency: 2 + N_COLS*DWELL + DEBOUNCE + 1 clocks.
- Release latency, rows low to key_down low: 2 + DEBOUNCE + 1 clocks.
- cols changes only on column advance and never glitches. Rows are sampled at least DWELL-1 clocks after a column change.
- Throughput: one pop per clock.

## Structure

- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, HELD};
  - KEY_W computation function;
  - constant table mapping 4×4 key index to calculator symbols (0-9, +, -, ×, =, CLR, BKSP) for the main FSM.
- Sub-module keypad_event_fifo (parameters WIDTH, DEPTH) holds storage, level and the full/empty/overflow logic. The scanner FSM, synchroniser and counters live in the top block.

## Test plan

- N_ROWS = N_COLS = 4, DWELL = 16, DEBOUNCE = 8, key (row 2, col 1) held clean → exactly one event, key_code = 9, key_down high, released after 2+8+1 clocks of low rows.
- Press with 3-clock bounce pulses, then stable → no event during the bounces; a single code 9 after the stable DEBOUNCE window.
- REPEAT_EN = 1, REPEAT_DLY = 64, key 5 held 300 clocks after debounce → 1 initial + 4 repeat pushes of code 5.
- key_ready = 0, 6 distinct presses, FIFO_DEPTH = 4 → fifo_level = 4, overflow = 1, pops return the first 4 codes in order; ovf_clr clears overflow.
- RESET asserted in HELD with 2 queued events → cols = 0001, key_valid = 0, fifo_level = 0 in the same cycle.
- Rows 1 and 3 pressed together in col 0, then EN dropped mid-DEBOUNCE → no event. Repeating with EN held high → code 4 (lowest row wins).
